// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator core: opcodes, skip
// conditions, FSM state encoding and small decode helpers.
package cpu_pkg;

    localparam logic [7:0] OP_HALT  = 8'h00;
    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_ADD2  = 8'h02;
    localparam logic [7:0] OP_LOAD  = 8'h03;
    localparam logic [7:0] OP_STORE = 8'h04;
    localparam logic [7:0] OP_SUB   = 8'h05;
    localparam logic [7:0] OP_SKIP  = 8'h06;
    localparam logic [7:0] OP_JUMP  = 8'h07;

    localparam logic [1:0] SKIP_ZERO  = 2'b00;
    localparam logic [1:0] SKIP_NEG   = 2'b01;
    localparam logic [1:0] SKIP_POS   = 2'b10;
    localparam logic [1:0] SKIP_NEVER = 2'b11;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] operand;
    } instr_t;

    // Operand bit 0 is dropped so every data/jump address is word aligned.
    function automatic logic [15:0] calc_ea(input logic [7:0] operand);
        return {8'h00, operand[7:1], 1'b0};
    endfunction

    function automatic logic skip_taken(input logic [15:0] acc, input logic [1:0] cond);
        logic taken;
        taken = 1'b0;
        case (cond)
            SKIP_ZERO: taken = (acc == 16'h0000);
            SKIP_NEG:  taken = acc[15];
            SKIP_POS:  taken = (acc != 16'h0000) && !acc[15];
            default:   taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/cpu_if.sv
// Memory bus between the core (master) and an asynchronous-read memory (slave).
interface cpu_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] mem_wdata;
    logic        mem_we;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/cpu_alu.sv
// Combinational accumulator datapath; opcodes that do not touch ACC pass it through.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [15:0] acc,
    input  logic [15:0] operand,
    input  logic [7:0]  opcode,
    output logic [15:0] result
);

    always_comb begin
        result = acc;
        case (opcode)
            OP_ADD, OP_ADD2: result = acc + operand;
            OP_SUB:          result = acc - operand;
            OP_LOAD:         result = operand;
            default:         result = acc;
        endcase
    end

endmodule

// File: rtl/cpu_core.sv
// Two-cycle (FETCH/EXEC) 16-bit accumulator machine with a single memory port.
module cpu_core
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    cpu_if.master       bus,
    output logic [15:0] pc,
    output logic [15:0] acc,
    output logic        halted
);

    logic [1:0]  state;
    instr_t      ir;
    logic [15:0] ea;
    logic [15:0] pc_inc;
    logic [15:0] alu_result;

    assign ea     = calc_ea(ir.operand);
    assign pc_inc = pc + 16'd2;
    assign halted = (state == ST_HALT);

    cpu_alu u_alu (
        .acc     (acc),
        .operand (bus.mem_rdata),
        .opcode  (ir.opcode),
        .result  (alu_result)
    );

    // The write strobe is gated by rst so a reset landing on a STORE wins.
    always_comb begin
        bus.mem_addr  = (state == ST_EXEC) ? ea : pc;
        bus.mem_wdata = acc;
        bus.mem_we    = (state == ST_EXEC) && (ir.opcode == OP_STORE) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            acc   <= 16'h0000;
            ir    <= '0;
            state <= ST_FETCH;
        end else begin
            case (state)
                ST_FETCH: begin
                    ir    <= bus.mem_rdata;
                    pc    <= pc_inc;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    acc <= alu_result;
                    if (ir.opcode == OP_JUMP) begin
                        pc <= ea;
                    end else if (ir.opcode == OP_SKIP && skip_taken(acc, ir.operand[1:0])) begin
                        pc <= pc_inc;
                    end
                    state <= (ir.opcode == OP_HALT) ? ST_HALT : ST_FETCH;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Directed program-level bench for cpu_core: expectations are queued per
// program and drained against the DUT once it halts.
module tb_cpu_core;

    localparam int SEL_PC   = 0;
    localparam int SEL_ACC  = 1;
    localparam int SEL_MEM  = 2;
    localparam int SEL_CYC  = 3;
    localparam int SEL_HALT = 4;

    typedef struct {
        int          sel;
        logic [15:0] addr;
        logic [15:0] value;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc;
    logic [15:0] acc;
    logic        halted;

    logic [15:0] mem [0:32767];
    logic        clear_en  = 1'b0;
    logic        load_en   = 1'b0;
    logic [14:0] load_idx  = '0;
    logic [15:0] load_data = '0;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cycles = 0;

    logic [15:0] fib_prog [16] = '{
        16'h0324, 16'h0120, 16'h0424, 16'h0324, 16'h0222, 16'h0424, 16'h0322, 16'h0420,
        16'h0324, 16'h0422, 16'h0326, 16'h0128, 16'h0426, 16'h0600, 16'h0700, 16'h0000
    };

    always #5 clk = ~clk;

    cpu_if bus ();

    cpu_core #(.RESET_PC(16'h0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .pc     (pc),
        .acc    (acc),
        .halted (halted)
    );

    assign bus.mem_rdata = mem[bus.mem_addr[15:1]];

    // Backdoor clear/load share the single write process with the DUT's stores.
    always @(posedge clk) begin
        if (clear_en) begin
            for (int i = 0; i < 32768; i++) mem[i] <= 16'h0000;
        end else if (load_en) begin
            mem[load_idx] <= load_data;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[15:1]] <= bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [15:0] addr,
                              input logic [15:0] value);
        exp_t e;
        e.sel   = sel;
        e.addr  = addr;
        e.value = value;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_output();
        exp_t        e;
        string       t;
        logic [15:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            case (e.sel)
                SEL_PC:   obs = pc;
                SEL_ACC:  obs = acc;
                SEL_MEM:  obs = mem[e.addr[15:1]];
                SEL_CYC:  obs = 16'(cycles);
                SEL_HALT: obs = {15'b0, halted};
                default:  obs = 16'hxxxx;
            endcase
            check(t, obs, e.value);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b1;
        clear_en = 1'b1;
        @(negedge clk);
        clear_en = 1'b0;
    endtask

    task automatic load_word(input logic [15:0] addr, input logic [15:0] data);
        load_idx  = addr[15:1];
        load_data = data;
        load_en   = 1'b1;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic run_program(input int max_cycles);
        rst    = 1'b0;
        cycles = 0;
        while (!halted && cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
        end
        if (!halted) check("halt_timeout", {15'b0, halted}, 16'h0001);
        check("addr_even", {15'b0, bus.mem_addr[0]}, 16'h0000);
    endtask

    initial begin
        logic [15:0] skip_val [4] = '{16'hFFFF, 16'h0001, 16'h0001, 16'h0000};
        logic [15:0] skip_ins [4] = '{16'h0601, 16'h0600, 16'h0602, 16'h0603};
        logic        skip_tkn [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

        $display("[TB] reset state and bare HALT");
        apply_reset();
        @(negedge clk);
        expect_val("rst_pc", SEL_PC, 16'h0, 16'h0000);
        expect_val("rst_acc", SEL_ACC, 16'h0, 16'h0000);
        expect_val("rst_halted", SEL_HALT, 16'h0, 16'h0000);
        check_output();
        run_program(20);
        expect_val("halt_cycles", SEL_CYC, 16'h0, 16'd2);
        expect_val("halt_pc", SEL_PC, 16'h0, 16'h0002);
        expect_val("halt_acc", SEL_ACC, 16'h0, 16'h0000);
        check_output();
        repeat (5) @(negedge clk);
        expect_val("halt_hold_pc", SEL_PC, 16'h0, 16'h0002);
        expect_val("halt_hold_flag", SEL_HALT, 16'h0, 16'h0001);
        check_output();
        check("halt_no_we", {15'b0, bus.mem_we}, 16'h0000);

        $display("[TB] LOAD/STORE round trip");
        apply_reset();
        load_word(16'h0000, 16'h0320);
        load_word(16'h0002, 16'h0422);
        load_word(16'h0004, 16'h0000);
        load_word(16'h0020, 16'h1234);
        expect_val("ls_mem22", SEL_MEM, 16'h0022, 16'h1234);
        expect_val("ls_acc", SEL_ACC, 16'h0, 16'h1234);
        expect_val("ls_cycles", SEL_CYC, 16'h0, 16'd6);
        run_program(50);
        check_output();

        $display("[TB] Fibonacci loop");
        apply_reset();
        for (int i = 0; i < 16; i++) load_word(16'(2 * i), fib_prog[i]);
        load_word(16'h0020, 16'h0000);
        load_word(16'h0022, 16'h0001);
        load_word(16'h0024, 16'h0000);
        load_word(16'h0026, 16'h0003);
        load_word(16'h0028, 16'hFFFF);
        expect_val("fib_a", SEL_MEM, 16'h0020, 16'd3);
        expect_val("fib_b", SEL_MEM, 16'h0022, 16'd7);
        expect_val("fib_sum", SEL_MEM, 16'h0024, 16'd7);
        expect_val("fib_ctr", SEL_MEM, 16'h0026, 16'd0);
        expect_val("fib_pc", SEL_PC, 16'h0, 16'h0020);
        expect_val("fib_cycles", SEL_CYC, 16'h0, 16'd90);
        run_program(200);
        check_output();

        for (int k = 0; k < 4; k++) begin
            $display("[TB] SKIP case %0d", k);
            apply_reset();
            load_word(16'h0000, 16'h0340);
            load_word(16'h0002, skip_ins[k]);
            load_word(16'h0004, 16'h0442);
            load_word(16'h0006, 16'h0000);
            load_word(16'h0040, skip_val[k]);
            load_word(16'h0042, 16'hDEAD);
            expect_val($sformatf("skip%0d_marker", k), SEL_MEM, 16'h0042,
                       skip_tkn[k] ? 16'hDEAD : skip_val[k]);
            expect_val($sformatf("skip%0d_cycles", k), SEL_CYC, 16'h0,
                       skip_tkn[k] ? 16'd6 : 16'd8);
            expect_val($sformatf("skip%0d_pc", k), SEL_PC, 16'h0, 16'h0008);
            run_program(50);
            check_output();
        end

        $display("[TB] arithmetic wrap");
        apply_reset();
        load_word(16'h0000, 16'h0340);
        load_word(16'h0002, 16'h0142);
        load_word(16'h0004, 16'h0444);
        load_word(16'h0006, 16'h0346);
        load_word(16'h0008, 16'h0542);
        load_word(16'h000A, 16'h0000);
        load_word(16'h0040, 16'h7FFF);
        load_word(16'h0042, 16'h0001);
        load_word(16'h0046, 16'h0000);
        expect_val("wrap_add", SEL_MEM, 16'h0044, 16'h8000);
        expect_val("wrap_sub", SEL_ACC, 16'h0, 16'hFFFF);
        run_program(50);
        check_output();

        $display("[TB] store into a later instruction");
        apply_reset();
        load_word(16'h0000, 16'h0320);
        load_word(16'h0002, 16'h0406);
        load_word(16'h0004, 16'h0322);
        load_word(16'h0006, 16'h0324);
        load_word(16'h0008, 16'h0000);
        load_word(16'h0020, 16'h0000);
        load_word(16'h0022, 16'h0005);
        load_word(16'h0024, 16'h0099);
        expect_val("smc_acc", SEL_ACC, 16'h0, 16'h0005);
        expect_val("smc_pc", SEL_PC, 16'h0, 16'h0008);
        expect_val("smc_cycles", SEL_CYC, 16'h0, 16'd8);
        run_program(50);
        check_output();

        $display("[TB] reset during STORE execute");
        apply_reset();
        load_word(16'h0000, 16'h0320);
        load_word(16'h0002, 16'h0422);
        load_word(16'h0004, 16'h0000);
        load_word(16'h0020, 16'h1234);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("store_we_armed", {15'b0, bus.mem_we}, 16'h0001);
        rst = 1'b1;
        #1;
        check("rst_blocks_we", {15'b0, bus.mem_we}, 16'h0000);
        @(negedge clk);
        expect_val("rst_store_mem", SEL_MEM, 16'h0022, 16'h0000);
        expect_val("rst_store_pc", SEL_PC, 16'h0, 16'h0000);
        expect_val("rst_store_acc", SEL_ACC, 16'h0, 16'h0000);
        check_output();
        rst = 1'b0;
        @(negedge clk);
        check("restart_pc", pc, 16'h0002);
        check("restart_ea", bus.mem_addr, 16'h0020);
        rst = 1'b1;
        @(negedge clk);
        expect_val("restart_mem22", SEL_MEM, 16'h0022, 16'h1234);
        expect_val("restart_cycles", SEL_CYC, 16'h0, 16'd6);
        run_program(50);
        check_output();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 Clock and reset SHALL be a single clock and a synchronous, active-high reset.
REQ-002 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 mem_addr  output  16  byte address, always even (bit 0 = 0).
REQ-006 mem_rdata  input  16  word at mem_addr; asynchronous read, valid in the same cycle.
REQ-007 mem_wdata  output  16  word to store.
REQ-008 mem_we  output  1  write strobe; memory writes mem_wdata at mem_addr on the same rising edge.
REQ-009 pc  output  16  current program counter.
REQ-010 acc  output  16  accumulator.
REQ-011 halted  output  1  high once HALT has executed.

Function
REQ-012 The core SHALL be a 16-bit accumulator machine with registers PC[15:0], IR[15:0] and ACC[15:0].
REQ-013 Instruction format SHALL be opcode = IR[15:8] and operand = IR[7:0]; EA = {8'h00, operand[7:1], 1'b0}.
REQ-014 Opcodes:
- 0x00 HALT.
- 0x01 ADD: ACC += M[EA].
- 0x02 ADD, an alias of 0x01.
- 0x03 LOAD: ACC = M[EA].
- 0x04 STORE: M[EA] = ACC.
- 0x05 SUB: ACC -= M[EA].
- 0x06 SKIP: conditional skip; see REQ-020.
- 0x07 JUMP: PC = EA.
- Any other value is a NOP.
REQ-015 Arithmetic SHALL be 16-bit two's complement, wrapping modulo 2^16, with no flags.
REQ-016 FSM states SHALL be FETCH, EXEC and HALT.
REQ-017 FETCH (one cycle):
- mem_addr = PC.
- IR <= mem_rdata.
- PC <= PC+2, wrapping 16'hFFFE -> 16'h0000.
- Next state EXEC.
REQ-018 EXEC (one cycle): mem_addr = EA; the opcode action completes at the end of the cycle; next state FETCH, or HALT for opcode 0x00.
REQ-019 Every instruction SHALL take exactly 2 clock cycles.
REQ-020 SKIP SHALL add a further 2 to PC when its condition holds, selected by operand[1:0]:
- 00: ACC == 0.
- 01: ACC[15] == 1 (negative).
- 10: ACC != 0 and ACC[15] == 0 (positive).
- 11: never.
REQ-021 mem_we SHALL be high only in the EXEC cycle of STORE, with mem_wdata = ACC; mem_wdata = ACC at all other times.
REQ-022 HALT state SHALL hold:
- halted = 1.
- mem_we = 0.
- PC, ACC and IR unchanged until rst.
REQ-023 JUMP SHALL take priority over PC increment; the target's operand bit 0 is ignored.
REQ-024 A STORE to the address of a later instruction SHALL affect that instruction's next fetch (no prefetch).

Reset
REQ-025 With rst high at a rising edge:
- PC <= RESET_PC.
- ACC <= 0.
- IR <= 0.
- State <= FETCH.
- halted <= 0.
REQ-026 Reset SHALL take effect in any state, including mid-instruction and HALT, and SHALL override a STORE in the same cycle (mem_we low while rst is high).

Structure
REQ-027 Opcode constants (OP_HALT..OP_JUMP), skip-condition codes and FSM state encoding SHALL live in a shared package cpu_pkg.
REQ-028 One sub-module, cpu_alu (combinational: ACC, operand, opcode -> result), is natural; control and registers stay in cpu_core.

Verification
REQ-029 Reset then run a program with only 0x0000 at address 0 -> halted = 1 after 2 cycles, PC = 0x0002, ACC = 0.
REQ-030 LOAD and STORE round trip:
- Stimulus: program 0x0320, 0x0422, 0x0000 with M[0x20] = 0x1234.
- Response: M[0x22] = 0x1234, acc = 0x1234, halted after 6 cycles.
REQ-031 Fibonacci loop:
- Program at 0x00..0x1E: 0324, 0120, 0424, 0324, 0222, 0424, 0322, 0420, 0324, 0422, 0326, 0128, 0426, 0600, 0700, 0000.
- Data: A@0x20 = 0, B@0x22 = 1, Sum@0x24 = 0, Ctr@0x26 = 3, Neg1@0x28 = 0xFFFF.
- Response: halted after 90 cycles with A = 3, B = 7, Sum = 7, Ctr = 0, PC = 0x0020.
REQ-032 SKIP:
- ACC = 0xFFFF with 0x0601: skip taken.
- ACC = 0x0001 with 0x0600: not taken.
- ACC = 0x0001 with 0x0602: taken.
- With 0x0603: never taken.
REQ-033 Arithmetic wrap: 0x7FFF + 0x0001 -> ACC = 0x8000; 0x0000 - 0x0001 -> 0xFFFF.
REQ-034 Assert rst during the EXEC cycle of a STORE -> no memory write, PC = 0, ACC = 0, fetch restarts at 0.
